// File: rtl/ram_req_bridge_pkg.sv
// Shared definitions for the line-RAM request bridge and its merge helper.
// No logic; latency n/a; backpressure n/a.
// Holds RAM geometry defaults and the bridge FSM state encoding.
package ram_req_bridge_pkg;

    localparam int RAM_DW = 128;
    localparam int RAM_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RDWAIT = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_strb_merge.sv
// Per-byte mux: strobed bytes from i_new, others from i_old.
// Purely combinational, zero latency; no backpressure.
// Shared with the store buffer, so it stays free of any bridge state.
module ram_strb_merge #(
    parameter int DW = 128,
    parameter int SW = DW / 8
) (
    input  logic [SW-1:0] i_strb,
    input  logic [DW-1:0] i_new,
    input  logic [DW-1:0] i_old,
    output logic [DW-1:0] o_merged
);

    for (genvar g = 0; g < SW; g++) begin : g_byte
        assign o_merged[8*g +: 8] = i_strb[g] ? i_new[8*g +: 8] : i_old[8*g +: 8];
    end

endmodule

// File: rtl/ram_req_bridge.sv
// Valid/ready front-end for the 128-bit line RAM; partial writes become read-modify-write.
// Latency: full write response at accept+1, read and partial write at accept+2.
// One request outstanding; req_ready drops while a RAM read is in flight or a response is stalled.
module ram_req_bridge
    import ram_req_bridge_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_wen,
    output logic [DW-1:0]     resp_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int SW = DW / 8;

    state_e          r_state;
    state_e          w_next;
    logic [AW-1:0]   r_addr;
    logic            r_wen;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic            r_resp_wen;
    logic [DW-1:0]   r_resp_rdata;

    logic            w_accept;
    logic            w_full;
    logic [DW-1:0]   w_merged;

    assign req_ready  = (r_state == ST_IDLE) | ((r_state == ST_RESP) & resp_ready);
    assign w_accept   = req_valid & req_ready;
    assign w_full     = req_wen & (&req_wstrb);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_wen   = r_resp_wen;
    assign resp_rdata = r_resp_rdata;

    // Merge latched write bytes over the line returned by the RDWAIT read.
    ram_strb_merge #(
        .DW (DW),
        .SW (SW)
    ) u_merge (
        .i_strb   (r_wstrb),
        .i_new    (r_wdata),
        .i_old    (ram_rdata),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next    = r_state;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = r_addr;
        ram_wdata = r_wdata;

        if (w_accept) begin
            ram_addr = req_addr;
            if (w_full) begin
                ram_wen   = 1'b1;
                ram_wdata = req_wdata;
                w_next    = ST_RESP;
            end else begin
                ram_ren = 1'b1;
                w_next  = ST_RDWAIT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_RDWAIT: begin
                    ram_wen   = r_wen;
                    ram_wdata = w_merged;
                    w_next    = ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        w_next = ST_IDLE;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end

        // Keeps a half-finished RMW from landing while reset is held.
        if (!rst_n) begin
            ram_ren = 1'b0;
            ram_wen = 1'b0;
            w_next  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_resp_wen   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_wen      <= req_wen;
                r_wdata    <= req_wdata;
                r_wstrb    <= req_wstrb;
                r_resp_wen <= req_wen;
                if (w_full) begin
                    r_resp_rdata <= req_wdata;
                end
            end else if (r_state == ST_RDWAIT) begin
                r_resp_rdata <= r_wen ? w_merged : ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_req_bridge.sv
// Bench for ram_req_bridge with a behavioural 1-cycle line RAM.
// Model predicts responses and RAM port activity from the request stream.
module tb_ram_req_bridge;

    localparam int DW = 128;
    localparam int AW = 16;
    localparam int SW = DW / 8;

    localparam logic [127:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2   = 128'h00112233_44556677_8899AABB_CCDDEEAA;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [SW-1:0]   req_wstrb;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_wen;
    logic [DW-1:0]   resp_rdata;
    logic [AW-1:0]   ram_addr;
    logic            ram_ren;
    logic            ram_wen;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int resp_count  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_req_bridge #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_wen   (resp_wen),
        .resp_rdata (resp_rdata),
        .ram_addr   (ram_addr),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Line RAM: registered read, whole-line write.
    logic [DW-1:0] ram_mem [0:65535];
    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model + per-cycle compare ----------------
    typedef struct {
        logic         wen;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t           q[$];
    logic [127:0]   mm [logic [15:0]];
    bit             seen   = 0;
    bit             pend_v = 0;
    int             pend_cyc;
    logic [15:0]    pend_addr;
    logic [127:0]   pend_data;

    always @(negedge clk) begin
        logic         e_ren, e_wen;
        logic [15:0]  e_addr;
        logic [127:0] e_wdata, old, mrg;
        exp_t         ent;
        if (!rst_n) begin
            chk("rst_ram_quiet", {126'd0, ram_ren, ram_wen}, 128'd0);
            q.delete();
            pend_v = 0;
            seen   = 0;
        end else begin
            e_ren = 0; e_wen = 0; e_addr = '0; e_wdata = '0;
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("resp_spurious", {127'd0, resp_valid}, 128'd0);
                end else begin
                    if (!seen) chk("resp_latency", q[0].cyc, cyc);
                    seen = 1;
                    chk("resp_rdata", resp_rdata, q[0].data);
                    chk("resp_wen", {127'd0, resp_wen}, {127'd0, q[0].wen});
                    if (resp_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                        resp_count++;
                    end
                end
            end else if (q.size() > 0 && (seen || cyc >= q[0].cyc)) begin
                chk("resp_present", {127'd0, resp_valid}, 128'd1);
            end
            if (pend_v && cyc == pend_cyc) begin
                e_wen = 1; e_addr = pend_addr; e_wdata = pend_data;
                mm[pend_addr] = pend_data;
                pend_v = 0;
            end
            if (req_valid && req_ready) begin
                old = mm.exists(req_addr) ? mm[req_addr] : '0;
                e_addr = req_addr;
                if (!req_wen) begin
                    ent = '{1'b0, old, cyc + 2};
                    e_ren = 1;
                end else if (req_wstrb == 16'hFFFF) begin
                    ent = '{1'b1, req_wdata, cyc + 1};
                    mm[req_addr] = req_wdata;
                    e_wen = 1; e_wdata = req_wdata;
                end else begin
                    for (int b = 0; b < SW; b++)
                        mrg[8*b +: 8] = req_wstrb[b] ? req_wdata[8*b +: 8] : old[8*b +: 8];
                    ent = '{1'b1, mrg, cyc + 2};
                    e_ren = 1;
                    pend_v = 1; pend_cyc = cyc + 1; pend_addr = req_addr; pend_data = mrg;
                end
                q.push_back(ent);
            end
            chk("ram_ren", {127'd0, ram_ren}, {127'd0, e_ren});
            chk("ram_wen", {127'd0, ram_wen}, {127'd0, e_wen});
            if (e_ren || e_wen) chk("ram_addr", {112'd0, ram_addr}, {112'd0, e_addr});
            if (e_wen) chk("ram_wdata", ram_wdata, e_wdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic w, input logic [15:0] a, input logic [127:0] d,
                        input logic [15:0] s, output logic a_ren, output logic a_wen);
        int n = 0;
        req_valid = 1; req_wen = w; req_addr = a; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", {127'd0, req_ready}, 128'd1);
        a_ren = ram_ren;
        a_wen = ram_wen;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic get_resp(output logic [127:0] d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        if (!resp_valid) chk("resp_timeout", {127'd0, resp_valid}, 128'd1);
        d = resp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [127:0] d, output int n);
        logic r0, w0;
        send(1'b0, a, '0, '0, r0, w0);
        get_resp(d, n);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic         ar, aw;
        logic [127:0] d;
        int           n, c0;

        rst_n = 0; req_valid = 0; req_wen = 0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_resp_valid", {127'd0, resp_valid}, 128'd0);
        chk("reset_resp_wen", {127'd0, resp_wen}, 128'd0);
        chk("reset_resp_rdata", resp_rdata, 128'd0);
        chk("reset_req_ready", {127'd0, req_ready}, 128'd1);
        @(posedge clk); #1;

        // 1: full write then read back
        send(1'b1, 16'h0010, D1, 16'hFFFF, ar, aw);
        chk("t1_acc_wen", {126'd0, ar, aw}, 128'd1);
        get_resp(d, n);
        chk("t1_lat", n, 1);
        chk("t1_data", d, D1);
        rd(16'h0010, d, n);
        chk("t1_rd_lat", n, 2);
        chk("t1_rd_data", d, D1);

        // 2: partial write, byte 0 only
        send(1'b1, 16'h0010, 128'h000000AA, 16'h0001, ar, aw);
        chk("t2_acc_ren", {126'd0, ar, aw}, 128'd2);
        @(negedge clk);
        chk("t2_rmw_wen", {127'd0, ram_wen}, 128'd1);
        chk("t2_rmw_wdata", ram_wdata, D2);
        get_resp(d, n);
        chk("t2_lat", n, 1);
        chk("t2_resp", d, D2);
        rd(16'h0010, d, n);
        chk("t2_rd_data", d, D2);

        // 3: backpressure on a read
        resp_ready = 0;
        send(1'b0, 16'h0010, '0, '0, ar, aw);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        chk("t3_lat", n, 2);
        chk("t3_data", resp_rdata, D2);
        c0 = resp_count;
        repeat (5) begin
            @(negedge clk);
            chk("t3_valid_held", {127'd0, resp_valid}, 128'd1);
            chk("t3_data_held", resp_rdata, D2);
            chk("t3_req_ready", {127'd0, req_ready}, 128'd0);
            chk("t3_ram_idle", {126'd0, ram_ren, ram_wen}, 128'd0);
        end
        @(posedge clk); #1 resp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_released", {127'd0, resp_valid}, 128'd0);
        chk("t3_one_resp", resp_count, c0 + 1);
        @(posedge clk); #1;

        // 4: eight back-to-back full writes
        for (int i = 0; i < 8; i++) begin
            req_valid = 1; req_wen = 1; req_addr = 16'(i);
            req_wdata = {4{32'hCAFE_0000 | i}}; req_wstrb = 16'hFFFF;
            @(negedge clk);
            chk("t4_b2b_ready", {127'd0, req_ready}, 128'd1);
            @(posedge clk); #1;
        end
        req_valid = 0;
        repeat (2) @(posedge clk); #1;
        rd(16'h0003, d, n);
        chk("t4_rd3", d, 128'hCAFE0003_CAFE0003_CAFE0003_CAFE0003);

        // 5: reset during RDWAIT of a partial write
        send(1'b1, 16'h0020, ONES, 16'hFFFF, ar, aw);
        get_resp(d, n);
        send(1'b1, 16'h0020, '0, 16'h0001, ar, aw);
        rst_n = 0;
        @(negedge clk);
        chk("t5_no_wen", {127'd0, ram_wen}, 128'd0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("t5_resp_valid", {127'd0, resp_valid}, 128'd0);
        chk("t5_idle_ready", {127'd0, req_ready}, 128'd1);
        chk("t5_mem", ram_mem[16'h0020], ONES);
        @(posedge clk); #1;
        rd(16'h0020, d, n);
        chk("t5_rd", d, ONES);

        // 6: zero-strobe write is an RMW that leaves the line alone
        send(1'b1, 16'h0010, 128'hDEADBEEF, 16'h0000, ar, aw);
        chk("t6_acc_ren", {126'd0, ar, aw}, 128'd2);
        get_resp(d, n);
        chk("t6_resp", d, D2);
        rd(16'h0010, d, n);
        chk("t6_rd", d, D2);

        repeat (3) @(posedge clk);
        chk("drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
